axil2reg_bridge: RTL and testbench

- AXI4-Lite slave that converts bus transactions into the single-cycle register strobe interface (reg_wren/reg_wraddr/reg_wrdata, reg_rden/reg_rdaddr/reg_rddata) consumed by register-file blocks.
- Sits directly upstream of the register file; one outstanding transaction per direction.
- Read and write channels run independent FSMs.

---
 rtl/axil2reg_bridge.sv | 197 +++++++++++++++++++
 tb/tb_axil2reg_bridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/axil2reg_bridge.sv
// AXI4-Lite slave that turns bus reads/writes into single-cycle register-file strobes.
// Read and write sides are independent FSMs, each with one transaction in flight.
module axil2reg_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 2,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic                      reg_wren,
    output logic [REG_ADDR_WIDTH-1:0] reg_wraddr,
    output logic [DATA_WIDTH-1:0]     reg_wrdata,
    output logic                      reg_rden,
    output logic [REG_ADDR_WIDTH-1:0] reg_rdaddr,
    input  logic [DATA_WIDTH-1:0]     reg_rddata
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_STROBE, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_STROBE, R_RESP} r_state_e;

    w_state_e                  w_state_q, w_state_d;
    logic                      aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [REG_ADDR_WIDTH-1:0] aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0]     w_data_q, w_data_d;
    logic [DATA_WIDTH/8-1:0]   w_strb_q, w_strb_d;
    logic [REG_ADDR_WIDTH-1:0] reg_wraddr_q, reg_wraddr_d;
    logic [DATA_WIDTH-1:0]     reg_wrdata_q, reg_wrdata_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      awready_q, awready_d, wready_q, wready_d;

    r_state_e                  r_state_q, r_state_d;
    logic                      arready_q, arready_d;
    logic [REG_ADDR_WIDTH-1:0] reg_rdaddr_q, reg_rdaddr_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

    logic aw_hs, w_hs, ar_hs;
    logic unused_addr_bits;

    // Address bits outside the word index alias by design.
    assign unused_addr_bits = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:REG_ADDR_WIDTH+2], s_axi_awaddr[1:0],
                                s_axi_araddr[AXI_ADDR_WIDTH-1:REG_ADDR_WIDTH+2], s_axi_araddr[1:0]};

    assign aw_hs = s_axi_awvalid && awready_q;
    assign w_hs  = s_axi_wvalid && wready_q;
    assign ar_hs = s_axi_arvalid && arready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q    <= W_IDLE;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            aw_idx_q     <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            reg_wraddr_q <= '0;
            reg_wrdata_q <= '0;
            bresp_q      <= RESP_OKAY;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
        end else begin
            w_state_q    <= w_state_d;
            aw_held_q    <= aw_held_d;
            w_held_q     <= w_held_d;
            aw_idx_q     <= aw_idx_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            reg_wraddr_q <= reg_wraddr_d;
            reg_wrdata_q <= reg_wrdata_d;
            bresp_q      <= bresp_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
        end
    end

    // Strobe outputs only move on entry to W_STROBE so they hold between writes.
    always_comb begin
        w_state_d    = w_state_q;
        aw_held_d    = aw_held_q;
        w_held_d     = w_held_q;
        aw_idx_d     = aw_idx_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        reg_wraddr_d = reg_wraddr_q;
        reg_wrdata_d = reg_wrdata_q;
        bresp_d      = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = s_axi_awaddr[REG_ADDR_WIDTH+1:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    w_data_d = s_axi_wdata;
                    w_strb_d = s_axi_wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_STROBE;
                    if (&w_strb_d) begin
                        reg_wraddr_d = aw_idx_d;
                        reg_wrdata_d = w_data_d;
                    end
                end
            end
            W_STROBE: begin
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                bresp_d   = (&w_strb_q) ? RESP_OKAY : RESP_SLVERR;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (s_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    always_comb begin
        s_axi_awready = awready_q;
        s_axi_wready  = wready_q;
        s_axi_bvalid  = (w_state_q == W_RESP);
        s_axi_bresp   = bresp_q;
        reg_wren      = (w_state_q == W_STROBE) && (&w_strb_q);
        reg_wraddr    = reg_wraddr_q;
        reg_wrdata    = reg_wrdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= R_IDLE;
            arready_q    <= 1'b0;
            reg_rdaddr_q <= '0;
            rdata_q      <= '0;
        end else begin
            r_state_q    <= r_state_d;
            arready_q    <= arready_d;
            reg_rdaddr_q <= reg_rdaddr_d;
            rdata_q      <= rdata_d;
        end
    end

    // Read data is sampled at the end of the strobe cycle, before any same-edge write lands.
    always_comb begin
        r_state_d    = r_state_q;
        reg_rdaddr_d = reg_rdaddr_q;
        rdata_d      = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    reg_rdaddr_d = s_axi_araddr[REG_ADDR_WIDTH+1:2];
                    r_state_d    = R_STROBE;
                end
            end
            R_STROBE: begin
                rdata_d   = reg_rddata;
                r_state_d = R_RESP;
            end
            R_RESP: begin
                if (s_axi_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_comb begin
        s_axi_arready = arready_q;
        s_axi_rvalid  = (r_state_q == R_RESP);
        s_axi_rdata   = rdata_q;
        s_axi_rresp   = RESP_OKAY;
        reg_rden      = (r_state_q == R_STROBE);
        reg_rdaddr    = reg_rdaddr_q;
    end

endmodule

// File: tb/tb_axil2reg_bridge.sv
// Scoreboard bench for axil2reg_bridge: directed AXI-Lite transactions against a small
// register-file stub; a negedge monitor pops expected strobes/responses as they appear.
module tb_axil2reg_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata, reg_wrdata, reg_rddata;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
    logic        arvalid = 0, arready, rvalid, rready = 1, reg_wren, reg_rden;
    logic [1:0]  bresp, rresp, reg_wraddr, reg_rdaddr;

    logic [31:0] regfile [4];
    logic [1:0]  exp_b[$];
    logic [31:0] exp_r[$];
    logic [33:0] exp_wr[$];
    logic [1:0]  exp_rd[$];
    int vectors = 0;
    int miscompares = 0;

    axil2reg_bridge dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_wren(reg_wren), .reg_wraddr(reg_wraddr), .reg_wrdata(reg_wrdata),
        .reg_rden(reg_rden), .reg_rdaddr(reg_rdaddr), .reg_rddata(reg_rddata)
    );

    always #5 clk = ~clk;

    // Register-file stub: combinational read, write lands at the clock edge.
    assign reg_rddata = regfile[reg_rdaddr];
    always @(posedge clk) if (reg_wren) regfile[reg_wraddr] <= reg_wrdata;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got unexpected event, expected none at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_wren) begin
                if (exp_wr.size() == 0) fail_event("wren_unexpected");
                else begin
                    logic [33:0] e;
                    e = exp_wr.pop_front();
                    check_output("wr_addr", reg_wraddr, e[33:32]);
                    check_output("wr_data", reg_wrdata, e[31:0]);
                end
            end
            if (reg_rden) begin
                if (exp_rd.size() == 0) fail_event("rden_unexpected");
                else check_output("rd_addr", reg_rdaddr, exp_rd.pop_front());
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) fail_event("b_unexpected");
                else check_output("bresp", bresp, exp_b.pop_front());
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) fail_event("r_unexpected");
                else begin
                    check_output("rdata", rdata, exp_r.pop_front());
                    check_output("rresp", rresp, 0);
                end
            end
        end
    end

    task automatic apply_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int lead, input bit wait_b);
        bit done = 0;
        bit aw_ok, w_ok;
        if (strb == 4'hF) exp_wr.push_back({addr[3:2], data});
        exp_b.push_back((strb == 4'hF) ? 2'b00 : 2'b10);
        wdata = data; wstrb = strb; wvalid = 1;
        if (lead == 0) begin awaddr = addr; awvalid = 1; end
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            @(negedge clk);
            if (lead > 0 && cyc == 1) check_output("wready_while_held", wready, 0);
            aw_ok = awvalid && awready;
            w_ok  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_ok) awvalid = 0;
            if (w_ok) wvalid = 0;
            if (lead > 0 && cyc + 1 == lead) begin awaddr = addr; awvalid = 1; end
            if (!awvalid && !wvalid && cyc + 1 >= lead) done = 1;
        end
        if (!done) begin fail_event("aw_w_timeout"); awvalid = 0; wvalid = 0; end
        check_output("wren_latency", reg_wren, (strb == 4'hF));
        @(posedge clk); #1;
        check_output("bvalid_latency", bvalid, 1);
        if (wait_b) begin
            done = 0;
            for (int cyc = 0; cyc < 30 && !done; cyc++) begin
                @(negedge clk);
                done = bvalid && bready;
                @(posedge clk); #1;
            end
            if (!done) fail_event("b_timeout");
        end
    endtask

    task automatic apply_read(input logic [31:0] addr, input logic [31:0] exp_data, input int hold,
                              input bit stop_at_strobe);
        bit done = 0;
        bit ok;
        exp_rd.push_back(addr[3:2]);
        exp_r.push_back(exp_data);
        araddr = addr; arvalid = 1; rready = (hold == 0);
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            @(negedge clk);
            ok = arready;
            @(posedge clk); #1;
            done = ok;
        end
        arvalid = 0;
        if (!done) fail_event("ar_timeout");
        check_output("rden_latency", reg_rden, 1);
        if (!stop_at_strobe) begin
            @(posedge clk); #1;
            check_output("rvalid_latency", rvalid, 1);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check_output("rvalid_held", rvalid, 1);
                check_output("arready_blocked", arready, 0);
                check_output("rdata_stable", rdata, exp_data);
            end
            rready = 1;
            done = 0;
            for (int cyc = 0; cyc < 30 && !done; cyc++) begin
                @(negedge clk);
                done = rvalid && rready;
                @(posedge clk); #1;
            end
            if (!done) fail_event("r_timeout");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        regfile[0] = 32'h1111_1111; regfile[1] = '0; regfile[2] = '0; regfile[3] = 32'hA5A5_A5A5;
        #2 rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_awready", awready, 0);
        check_output("rst_wready", wready, 0);
        check_output("rst_arready", arready, 0);
        check_output("rst_bvalid", bvalid, 0);
        check_output("rst_rvalid", rvalid, 0);
        check_output("rst_wren_rden", {reg_wren, reg_rden}, 0);
        check_output("rst_rdata", rdata, 0);
        check_output("rst_wraddr_rdaddr", {reg_wraddr, reg_rdaddr}, 0);
        rst = 0;
        repeat (2) @(posedge clk);
        #1;

        apply_write(32'h8, 32'hDEAD_BEEF, 4'hF, 0, 1);
        apply_write(32'h4, 32'h1234_5678, 4'hF, 2, 1);
        apply_read(32'h4, 32'h1234_5678, 0, 0);
        apply_write(32'h8, 32'h0000_0000, 4'h3, 0, 1);
        apply_read(32'h8, 32'hDEAD_BEEF, 0, 0);
        apply_read(32'hC, 32'hA5A5_A5A5, 5, 0);

        fork
            apply_write(32'h0, 32'h0000_0001, 4'hF, 0, 1);
            apply_read(32'h0, 32'h1111_1111, 0, 0);
        join
        apply_read(32'h0, 32'h0000_0001, 0, 0);

        bready = 0;
        apply_write(32'h4, 32'h0BAD_F00D, 4'hF, 0, 0);
        apply_read(32'h8, 32'hDEAD_BEEF, 0, 1);
        #2 rst = 1;
        #1;
        check_output("async_bvalid", bvalid, 0);
        check_output("async_rvalid", rvalid, 0);
        check_output("async_rden", reg_rden, 0);
        exp_b.delete(); exp_r.delete(); exp_rd.delete();
        @(posedge clk); #1;
        rst = 0; bready = 1;
        repeat (2) @(posedge clk);
        #1;

        apply_write(32'hC, 32'hCAFE_F00D, 4'hF, 0, 1);
        apply_read(32'hC, 32'hCAFE_F00D, 0, 0);
        apply_read(32'h1000_0005, 32'h0BAD_F00D, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check_output("sb_drain", exp_b.size() + exp_r.size() + exp_wr.size() + exp_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
